// File: rtl/lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// lcd_timing_gen
//   Parametrised RGB-LCD timing generator. Produces the panel pixel clock,
//   hsync, vsync and den, requests pixels from the frame source by (x,y) and
//   registers the returned pixel onto color one pixel tick later.
//
//   Pipeline:
//     stage 0 : h/v counters, pix_req / pix_x / pix_y / frame_start
//     stage 1 : color, den, hsync, vsync (stage-0 decodes delayed one tick)
//
//   Optional build macro:
//     TEST_PATTERN_EN - adds input pattern_sel; when selected (sampled at
//                       frame start) stage 1 drives eight vertical colour bars
//                       instead of pixel_in. Timing is identical either way.
// -----------------------------------------------------------------------------
module lcd_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 1,
  parameter int H_BP     = 43,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int V_SYNC   = 1,
  parameter int V_BP     = 12,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 1,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
`ifdef TEST_PATTERN_EN
  input  logic                pattern_sel,
`endif
  input  logic [COLOR_W-1:0]  pixel_in,
  output logic                pix_req,
  output logic [((H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1)-1:0] pix_x,
  output logic [((V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1)-1:0] pix_y,
  output logic                frame_start,
  output logic [COLOR_W-1:0]  color,
  output logic                hsync,
  output logic                vsync,
  output logic                den,
  output logic                clk_to_screen
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOT   = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;

  localparam int HW   = (H_TOT > 1)    ? $clog2(H_TOT)    : 1;
  localparam int VW   = (V_TOT > 1)    ? $clog2(V_TOT)    : 1;
  localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int DW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // ---------------------------------------------------------------------------
  // Decode helpers (integer compares so H_END == H_TOT never overflows HW bits)
  // ---------------------------------------------------------------------------
  function automatic logic h_in_active(input logic [HW-1:0] h);
    return (int'(h) >= H_START) && (int'(h) < H_END);
  endfunction

  function automatic logic v_in_active(input logic [VW-1:0] v);
    return (int'(v) >= V_START) && (int'(v) < V_END);
  endfunction

  function automatic logic h_in_sync(input logic [HW-1:0] h);
    return int'(h) < H_SYNC;
  endfunction

  function automatic logic v_in_sync(input logic [VW-1:0] v);
    return int'(v) < V_SYNC;
  endfunction

  function automatic logic [XW-1:0] col_of(input logic [HW-1:0] h);
    logic [HW-1:0] d;
    d = h - HW'(H_START);
    return XW'(d);
  endfunction

  function automatic logic [YW-1:0] row_of(input logic [VW-1:0] v);
    logic [VW-1:0] d;
    d = v - VW'(V_START);
    return YW'(d);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_n;
  logic          pix_ce;

  logic [0:0]    state;
  logic [0:0]    state_n;
  logic [HW-1:0] h_cnt;
  logic [HW-1:0] h_n;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_n;
  logic          end_of_frame;
  logic          frame_load;
  logic          stay_run;
  logic          run_n;

  logic [COLOR_W-1:0] stage1_pix;

  // ---------------------------------------------------------------------------
  // Optional colour-bar source
  // ---------------------------------------------------------------------------
`ifdef TEST_PATTERN_EN
  logic pattern_on;

  // Bar colours as wired on the panel: white, red, green, blue, repeated,
  // with black in the last slot.
  function automatic logic [15:0] bar_rgb565(input logic [XW-1:0] x);
    int bar;
    bar = (int'(x) * 8) / H_ACTIVE;
    case (bar)
      0, 4:    return 16'hffff;
      1, 5:    return 16'h001f;
      2, 6:    return 16'h07e0;
      3:       return 16'hf800;
      default: return 16'h0000;
    endcase
  endfunction

  // Pattern selection only changes on the tick that starts a frame, so a
  // frame is never half pattern, half live data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_on <= 1'b0;
    end else if (frame_load) begin
      pattern_on <= pattern_sel;
    end
  end

  // Pixel source for stage 1: bars keyed on the column being presented.
  always_comb begin
    stage1_pix = pattern_on ? COLOR_W'(bar_rgb565(pix_x)) : pixel_in;
  end
`else
  // Pixel source for stage 1: always the caller's data.
  always_comb begin
    stage1_pix = pixel_in;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic: divider, run/idle control, h/v counters
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pix_ce       = (div_cnt == DW'(CLK_DIV - 1));
    div_n        = pix_ce ? '0 : div_cnt + DW'(1);
    end_of_frame = (h_cnt == HW'(H_TOT - 1)) && (v_cnt == VW'(V_TOT - 1));
    state_n      = state;
    h_n          = h_cnt;
    v_n          = v_cnt;
    frame_load   = 1'b0;

    if (pix_ce) begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state_n    = ST_RUN;
            h_n        = '0;
            v_n        = '0;
            frame_load = 1'b1;
          end
        end
        default: begin
          if (end_of_frame) begin
            // A frame always runs to completion; en only decides whether
            // another one follows.
            h_n = '0;
            v_n = '0;
            if (en) begin
              frame_load = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (h_cnt == HW'(H_TOT - 1)) begin
            h_n = '0;
            v_n = v_cnt + VW'(1);
          end else begin
            h_n = h_cnt + HW'(1);
          end
        end
      endcase
    end

    run_n    = (state_n == ST_RUN);
    // Stage 1 only carries real decodes between two running ticks; entering
    // or leaving RUN presents the idle (reset) levels on the pins.
    stay_run = (state == ST_RUN) && run_n;
  end

  // ---------------------------------------------------------------------------
  // Pixel divider and panel clock: clk_to_screen rises half way through the
  // tick and falls on the pix_ce edge, so the panel samples mid-tick.
  // ---------------------------------------------------------------------------
  // NOTE: all state in always_ff uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt       <= '0;
      clk_to_screen <= 1'b0;
    end else begin
      div_cnt       <= div_n;
      clk_to_screen <= (state == ST_RUN) && (div_n >= DW'(HALF));
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: run state, counters and the pixel request for the coming tick
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_load;
      if (pix_ce) begin
        state <= state_n;
        h_cnt <= h_n;
        v_cnt <= v_n;
        if (run_n && h_in_active(h_n) && v_in_active(v_n)) begin
          pix_req <= 1'b1;
          pix_x   <= col_of(h_n);
          pix_y   <= row_of(v_n);
        end else begin
          pix_req <= 1'b0;
          pix_x   <= '0;
          pix_y   <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: LCD pins, one pixel tick behind the request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color <= '0;
      den   <= 1'b0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else if (pix_ce) begin
      if (stay_run) begin
        color <= pix_req ? stage1_pix : '0;
        den   <= pix_req;
        hsync <= h_in_sync(h_cnt) ? HS_POL : ~HS_POL;
        vsync <= v_in_sync(v_cnt) ? VS_POL : ~VS_POL;
      end else begin
        color <= '0;
        den   <= 1'b0;
        hsync <= ~HS_POL;
        vsync <= ~VS_POL;
      end
    end
  end

endmodule
